// File: rtl/rs_dec_syndrome_calc.sv
// rs_dec_syndrome_calc
// Byte-serial syndrome calculator for the RS(32,28) CIRC decoder.
// Absorbs one 32-symbol codeword, highest-degree symbol first, and Horner-
// evaluates r(x) at alpha^0..alpha^3 over GF(256) (poly 0x11D, alpha = 0x02).
// Syndromes are presented on held registers with a one-cycle sync pulse.
// Optional feature macro: RS_SYND_ZERO_FLAG_EN adds o_no_err, a held flag
// that is set when all four syndromes of the last codeword are zero.
module rs_dec_syndrome_calc (
    input  logic       i_clk,
    input  logic       i_res,
    input  logic       i_valid,
    input  logic       i_sof,
    input  logic [7:0] i_data,
    output logic [7:0] o_s0,
    output logic [7:0] o_s1,
    output logic [7:0] o_s2,
    output logic [7:0] o_s3,
    output logic       o_synd_sync,
`ifdef RS_SYND_ZERO_FLAG_EN
    output logic       o_no_err,
`endif
    output logic       o_abort
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_ACC  = 1'b1
    } state_t;

    // GF(256) multiply by alpha: shift left, reduce by 0x11D on carry-out
    function automatic logic [7:0] gf_mul_a1(input logic [7:0] x);
        gf_mul_a1 = {x[6:0], 1'b0} ^ (x[7] ? 8'h1D : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul_a2(input logic [7:0] x);
        gf_mul_a2 = gf_mul_a1(gf_mul_a1(x));
    endfunction

    function automatic logic [7:0] gf_mul_a3(input logic [7:0] x);
        gf_mul_a3 = gf_mul_a1(gf_mul_a2(x));
    endfunction

    state_t     state_q, state_d;
    logic [4:0] cnt_q, cnt_d;
    logic [7:0] acc0_q, acc0_d;
    logic [7:0] acc1_q, acc1_d;
    logic [7:0] acc2_q, acc2_d;
    logic [7:0] acc3_q, acc3_d;
    logic [7:0] s0_q, s0_d;
    logic [7:0] s1_q, s1_d;
    logic [7:0] s2_q, s2_d;
    logic [7:0] s3_q, s3_d;
    logic       sync_q, sync_d;
    logic       abort_q, abort_d;
    logic [7:0] nxt0, nxt1, nxt2, nxt3;
`ifdef RS_SYND_ZERO_FLAG_EN
    logic       no_err_q, no_err_d;
`endif

    // Horner step for each syndrome: acc_j * alpha^j + incoming symbol
    always_comb begin
        nxt0 = acc0_q ^ i_data;
        nxt1 = gf_mul_a1(acc1_q) ^ i_data;
        nxt2 = gf_mul_a2(acc2_q) ^ i_data;
        nxt3 = gf_mul_a3(acc3_q) ^ i_data;
    end

    // Next-state logic: start / accumulate / complete / abort decisions
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc0_d   = acc0_q;
        acc1_d   = acc1_q;
        acc2_d   = acc2_q;
        acc3_d   = acc3_q;
        s0_d     = s0_q;
        s1_d     = s1_q;
        s2_d     = s2_q;
        s3_d     = s3_q;
        sync_d   = 1'b0;
        abort_d  = 1'b0;
`ifdef RS_SYND_ZERO_FLAG_EN
        no_err_d = no_err_q;
`endif
        if (i_valid) begin
            if (i_sof) begin
                // A start-of-frame always (re)starts; an open codeword is dropped
                abort_d = (state_q == ST_ACC);
                acc0_d  = i_data;
                acc1_d  = i_data;
                acc2_d  = i_data;
                acc3_d  = i_data;
                cnt_d   = 5'd1;
                state_d = ST_ACC;
            end else if (state_q == ST_ACC) begin
                if (cnt_q == 5'd31) begin
                    // 32nd symbol: publish syndromes and close the codeword
                    s0_d    = nxt0;
                    s1_d    = nxt1;
                    s2_d    = nxt2;
                    s3_d    = nxt3;
                    sync_d  = 1'b1;
                    cnt_d   = 5'd0;
                    acc0_d  = 8'h00;
                    acc1_d  = 8'h00;
                    acc2_d  = 8'h00;
                    acc3_d  = 8'h00;
                    state_d = ST_IDLE;
`ifdef RS_SYND_ZERO_FLAG_EN
                    no_err_d = (nxt0 == 8'h00) && (nxt1 == 8'h00) &&
                               (nxt2 == 8'h00) && (nxt3 == 8'h00);
`endif
                end else begin
                    acc0_d = nxt0;
                    acc1_d = nxt1;
                    acc2_d = nxt2;
                    acc3_d = nxt3;
                    cnt_d  = cnt_q + 5'd1;
                end
            end
        end
    end

    // State and output registers; reset clears everything including held syndromes
    always_ff @(posedge i_clk) begin
        if (i_res) begin
            state_q  <= ST_IDLE;
            cnt_q    <= 5'd0;
            acc0_q   <= 8'h00;
            acc1_q   <= 8'h00;
            acc2_q   <= 8'h00;
            acc3_q   <= 8'h00;
            s0_q     <= 8'h00;
            s1_q     <= 8'h00;
            s2_q     <= 8'h00;
            s3_q     <= 8'h00;
            sync_q   <= 1'b0;
            abort_q  <= 1'b0;
`ifdef RS_SYND_ZERO_FLAG_EN
            no_err_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc0_q   <= acc0_d;
            acc1_q   <= acc1_d;
            acc2_q   <= acc2_d;
            acc3_q   <= acc3_d;
            s0_q     <= s0_d;
            s1_q     <= s1_d;
            s2_q     <= s2_d;
            s3_q     <= s3_d;
            sync_q   <= sync_d;
            abort_q  <= abort_d;
`ifdef RS_SYND_ZERO_FLAG_EN
            no_err_q <= no_err_d;
`endif
        end
    end

    assign o_s0        = s0_q;
    assign o_s1        = s1_q;
    assign o_s2        = s2_q;
    assign o_s3        = s3_q;
    assign o_synd_sync = sync_q;
    assign o_abort     = abort_q;
`ifdef RS_SYND_ZERO_FLAG_EN
    assign o_no_err    = no_err_q;
`endif

endmodule

// File: tb/tb_rs_dec_syndrome_calc.sv
// Directed testbench for rs_dec_syndrome_calc.
// Expected syndromes are hand-computed over GF(256), poly 0x11D, alpha=0x02.
module tb_rs_dec_syndrome_calc;

    logic       i_clk = 1'b0;
    logic       i_res = 1'b1;
    logic       i_valid = 1'b0;
    logic       i_sof = 1'b0;
    logic [7:0] i_data = 8'h00;
    logic [7:0] o_s0, o_s1, o_s2, o_s3;
    logic       o_synd_sync;
    logic       o_abort;
`ifdef RS_SYND_ZERO_FLAG_EN
    logic       o_no_err;
`endif

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int sync_cnt = 0;
    int abort_cnt = 0;
    int sync_cyc_last = 0;
    int sync_cyc_prev = 0;
    int base_sync;
    int base_abort;

    rs_dec_syndrome_calc dut (
        .i_clk      (i_clk),
        .i_res      (i_res),
        .i_valid    (i_valid),
        .i_sof      (i_sof),
        .i_data     (i_data),
        .o_s0       (o_s0),
        .o_s1       (o_s1),
        .o_s2       (o_s2),
        .o_s3       (o_s3),
        .o_synd_sync(o_synd_sync),
`ifdef RS_SYND_ZERO_FLAG_EN
        .o_no_err   (o_no_err),
`endif
        .o_abort    (o_abort)
    );

    always #5 i_clk = ~i_clk;

    always @(posedge i_clk) cyc <= cyc + 1;

    // Pulse monitor, sampled away from the active edge
    always @(negedge i_clk) begin
        if (o_synd_sync) begin
            sync_cnt      = sync_cnt + 1;
            sync_cyc_prev = sync_cyc_last;
            sync_cyc_last = cyc;
        end
        if (o_abort) abort_cnt = abort_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks = checks + 1;
        assert (obs === exp) else begin
            errors = errors + 1;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic sym(input logic sof, input logic [7:0] d);
        i_valid = 1'b1;
        i_sof   = sof;
        i_data  = d;
        @(posedge i_clk);
        #1;
    endtask

    task automatic idle(input int n);
        i_valid = 1'b0;
        i_sof   = 1'b0;
        i_data  = 8'h00;
        repeat (n) @(posedge i_clk);
        #1;
    endtask

    task automatic chk_s(input string tag, input logic [7:0] e0, input logic [7:0] e1,
                         input logic [7:0] e2, input logic [7:0] e3);
        chk({tag, "_s0"}, {24'h0, o_s0}, {24'h0, e0});
        chk({tag, "_s1"}, {24'h0, o_s1}, {24'h0, e1});
        chk({tag, "_s2"}, {24'h0, o_s2}, {24'h0, e2});
        chk({tag, "_s3"}, {24'h0, o_s3}, {24'h0, e3});
    endtask

    task automatic chk_noerr(input string tag, input logic e);
`ifdef RS_SYND_ZERO_FLAG_EN
        chk(tag, {31'h0, o_no_err}, {31'h0, e});
`else
        if (e === 1'bx) chk(tag, 32'h0, 32'h1);
`endif
    endtask

    // Full codeword with one nonzero symbol err at 0-based index pos
    task automatic send_cw(input logic [7:0] err, input int pos, input bit gaps);
        for (int i = 0; i < 32; i++) begin
            if (gaps && i != 0) begin
                i_valid = 1'b0;
                i_sof   = 1'b1;   // sof without valid must be ignored
                i_data  = 8'hA5;
                repeat ($urandom_range(0, 3)) @(posedge i_clk);
                #1;
            end
            sym(i == 0, (i == pos) ? err : 8'h00);
        end
    endtask

    initial begin
        // Reset
        repeat (3) @(posedge i_clk);
        #1;
        chk_s("rst", 8'h00, 8'h00, 8'h00, 8'h00);
        chk("rst_sync", {31'h0, o_synd_sync}, 32'h0);
        chk("rst_abort", {31'h0, o_abort}, 32'h0);
        chk_noerr("rst_noerr", 1'b0);
        i_res = 1'b0;
        idle(2);

        // All-zero codeword
        base_sync = sync_cnt;
        send_cw(8'h00, 0, 1'b0);
        chk("zero_sync", {31'h0, o_synd_sync}, 32'h1);
        chk_s("zero", 8'h00, 8'h00, 8'h00, 8'h00);
        chk_noerr("zero_noerr", 1'b1);
        idle(1);
        chk("zero_sync_low", {31'h0, o_synd_sync}, 32'h0);
        chk("zero_sync_cnt", sync_cnt - base_sync, 32'd1);

        // Single error 0x01 at x^1
        send_cw(8'h01, 30, 1'b0);
        chk("x1_sync", {31'h0, o_synd_sync}, 32'h1);
        chk_s("x1", 8'h01, 8'h02, 8'h04, 8'h08);
        chk_noerr("x1_noerr", 1'b0);
        idle(2);

        // Error 0x05 at x^2 with random gaps
        base_sync = sync_cnt;
        send_cw(8'h05, 29, 1'b1);
        chk("x2_sync", {31'h0, o_synd_sync}, 32'h1);
        chk_s("x2", 8'h05, 8'h14, 8'h50, 8'h5D);
        idle(3);
        chk("x2_sync_cnt", sync_cnt - base_sync, 32'd1);
        chk_s("x2_hold", 8'h05, 8'h14, 8'h50, 8'h5D);

        // Abort: 10 symbols then a new sof with a zero codeword
        base_sync  = sync_cnt;
        base_abort = abort_cnt;
        sym(1'b1, 8'h33);
        for (int i = 1; i < 10; i++) sym(1'b0, 8'h11 + 8'(i));
        sym(1'b1, 8'h00);
        chk("ab_pulse", {31'h0, o_abort}, 32'h1);
        chk_s("ab_untouched", 8'h05, 8'h14, 8'h50, 8'h5D);
        for (int i = 1; i < 31; i++) sym(1'b0, 8'h00);
        chk("ab_abort_low", {31'h0, o_abort}, 32'h0);
        chk("ab_no_early_sync", sync_cnt - base_sync, 32'd0);
        sym(1'b0, 8'h00);
        chk("ab_sync", {31'h0, o_synd_sync}, 32'h1);
        chk_s("ab", 8'h00, 8'h00, 8'h00, 8'h00);
        idle(2);
        chk("ab_abort_cnt", abort_cnt - base_abort, 32'd1);
        chk("ab_sync_cnt", sync_cnt - base_sync, 32'd1);

        // Back-to-back: A (x^1 error) then B (all zero) at full rate
        base_sync = sync_cnt;
        send_cw(8'h01, 30, 1'b0);
        chk_s("bb_a", 8'h01, 8'h02, 8'h04, 8'h08);
        for (int i = 0; i < 31; i++) sym(i == 0, 8'h00);
        chk_s("bb_hold", 8'h01, 8'h02, 8'h04, 8'h08);
        sym(1'b0, 8'h00);
        chk("bb_b_sync", {31'h0, o_synd_sync}, 32'h1);
        chk_s("bb_b", 8'h00, 8'h00, 8'h00, 8'h00);
        idle(2);
        chk("bb_sync_cnt", sync_cnt - base_sync, 32'd2);
        chk("bb_spacing", sync_cyc_last - sync_cyc_prev, 32'd32);

        // Reset mid-codeword after nonzero syndromes
        send_cw(8'h01, 30, 1'b0);
        idle(1);
        chk_s("pre_rst", 8'h01, 8'h02, 8'h04, 8'h08);
        base_sync  = sync_cnt;
        base_abort = abort_cnt;
        for (int i = 0; i < 20; i++) sym(i == 0, 8'h07);
        i_valid = 1'b1;
        i_sof   = 1'b0;
        i_data  = 8'h09;
        i_res   = 1'b1;
        @(posedge i_clk);
        #1;
        i_res = 1'b0;
        chk_s("mid_rst", 8'h00, 8'h00, 8'h00, 8'h00);
        chk_noerr("mid_rst_noerr", 1'b0);
        idle(1);
        send_cw(8'h00, 0, 1'b0);
        chk("mid_rst_sync", {31'h0, o_synd_sync}, 32'h1);
        chk_s("post_rst", 8'h00, 8'h00, 8'h00, 8'h00);
        idle(2);
        chk("mid_rst_sync_cnt", sync_cnt - base_sync, 32'd1);
        chk("mid_rst_abort_cnt", abort_cnt - base_abort, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
